// File: rtl/snn_soc_pkg.sv
// Shared SoC constants: data_sram window, out-DMA register offsets and FSM states.
// Pure declarations, no logic.
// Imported by the out DMA engine and its bench.
package snn_soc_pkg;

  // data_sram window in the SoC physical address map
  localparam logic [31:0] ADDR_DATA_BASE = 32'h0001_0000;
  localparam logic [31:0] ADDR_DATA_END  = 32'h0001_3FFF;

  // out-DMA register offsets (byte offsets, only [7:0] decoded)
  localparam logic [7:0] OUT_DMA_REG_DST  = 8'h00;
  localparam logic [7:0] OUT_DMA_REG_LEN  = 8'h04;
  localparam logic [7:0] OUT_DMA_REG_CTRL = 8'h08;
  localparam logic [7:0] OUT_DMA_REG_CNT  = 8'h0C;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    WR0  = 2'd2,
    WR1  = 2'd3
  } out_dma_state_t;

  // Byte-enable merge for partially written 32-bit registers
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = be[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/out_dma_engine.sv
// Write-back DMA: pops 64-bit output-FIFO entries, writes them as two 32-bit words to data_sram.
// Latency: START to first write 2 cycles with a non-empty FIFO; 3 cycles per entry.
// Backpressure: waits in WAIT while the FIFO is empty; OUT_DMA_TIMEOUT_EN bounds that wait.
module out_dma_engine
  import snn_soc_pkg::*;
#(
  parameter int ENTRY_W        = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic               req_write,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  input  logic [3:0]         req_wstrb,
  output logic [31:0]        rdata,
  output logic               out_fifo_pop,
  input  logic [ENTRY_W-1:0] out_fifo_rdata,
  input  logic               out_fifo_empty,
  output logic               dma_wr_en,
  output logic [31:0]        dma_wr_addr,
  output logic [31:0]        dma_wr_data,
  output logic [3:0]         dma_wr_be
);

  // An entry is always exactly two data_sram words
  if (ENTRY_W != 64) begin : g_entry_w_check
    $error("out_dma_engine: ENTRY_W must be 64");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
    $error("out_dma_engine: TIMEOUT_CYCLES must be at least 1");
  end

  out_dma_state_t     state;
  logic [31:0]        dst_reg;
  logic [31:0]        len_reg;
  logic [31:0]        ptr;
  logic [31:0]        rem;
  logic [31:0]        words_done;
  logic               done_bit;
  logic               err_bit;
  logic [ENTRY_W-1:0] entry_reg;

  logic [7:0] reg_off;
  logic       acc_wr;
  logic       wr_dst;
  logic       wr_len;
  logic       wr_ctrl;
  logic       start_req;
  logic       clr_done;
  logic       clr_err;
  logic       busy;
  logic       chk_ok;
  logic       chk_err;
  logic       start_go;
  logic       start_bad;
  logic       done_set;
  logic       err_set;
  logic       timeout_hit;
  logic [34:0] end_ext;
  logic       unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:8];

  assign reg_off   = req_addr[7:0];
  assign acc_wr    = req_valid & req_write;
  assign wr_dst    = acc_wr & (reg_off == OUT_DMA_REG_DST);
  assign wr_len    = acc_wr & (reg_off == OUT_DMA_REG_LEN);
  assign wr_ctrl   = acc_wr & (reg_off == OUT_DMA_REG_CTRL);
  assign start_req = wr_ctrl & req_wdata[0];
  assign clr_done  = wr_ctrl & req_wdata[1];
  assign clr_err   = wr_ctrl & req_wdata[2];
  assign busy      = (state != IDLE);

  // Last byte of the requested range, widened so a 32-bit wrap shows up in the top bits
  assign end_ext = {3'b000, dst_reg} + {1'b0, len_reg, 2'b00} - 35'd1;

  // START screening: first failing rule decides; LEN==0 completes without error
  always_comb begin
    chk_ok  = 1'b0;
    chk_err = 1'b0;
    if (len_reg[0]) begin
      chk_err = 1'b1;
    end else if (len_reg == 32'd0) begin
      chk_err = 1'b0;
    end else if (dst_reg[1:0] != 2'b00) begin
      chk_err = 1'b1;
    end else if ((dst_reg < ADDR_DATA_BASE) || (end_ext[34:32] != 3'd0) ||
                 (end_ext[31:0] > ADDR_DATA_END)) begin
      chk_err = 1'b1;
    end else begin
      chk_ok = 1'b1;
    end
  end

  assign start_go  = start_req & ~busy & chk_ok;
  assign start_bad = start_req & ~busy & ~chk_ok;
  assign done_set  = start_bad | ((state == WR1) && (rem == 32'd2)) | timeout_hit;
  assign err_set   = (start_bad & chk_err) | timeout_hit;

`ifdef OUT_DMA_TIMEOUT_EN
  logic [31:0] wait_cnt;
  logic [31:0] wait_cnt_inc;

  assign wait_cnt_inc = wait_cnt + 32'd1;
  assign timeout_hit  = (state == WAIT) && out_fifo_empty &&
                        (wait_cnt_inc == 32'(TIMEOUT_CYCLES));

  // Idle-wait counter: runs only in WAIT, restarts on each pop and on START
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 32'd0;
    end else if (start_go || out_fifo_pop) begin
      wait_cnt <= 32'd0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt_inc;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Programming registers; writes land even while a run is active (run uses its own copies)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_reg <= 32'd0;
      len_reg <= 32'd0;
    end else begin
      if (wr_dst) dst_reg <= apply_wstrb(dst_reg, req_wdata, req_wstrb);
      if (wr_len) len_reg <= apply_wstrb(len_reg, req_wdata, req_wstrb);
    end
  end

  // Sticky status: a hardware set in the same cycle as a W1C wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_bit <= 1'b0;
      err_bit  <= 1'b0;
    end else if (start_go) begin
      done_bit <= 1'b0;
      err_bit  <= 1'b0;
    end else begin
      done_bit <= (done_bit & ~clr_done) | done_set;
      err_bit  <= (err_bit & ~clr_err) | err_set;
    end
  end

  // Word counter: cleared by an accepted START, bumped on every data_sram write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_done <= 32'd0;
    end else if (start_go) begin
      words_done <= 32'd0;
    end else if (dma_wr_en) begin
      words_done <= words_done + 32'd1;
    end
  end

  // Transfer FSM with its working pointer, remaining count and entry holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 32'd0;
      rem       <= 32'd0;
      entry_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_go) begin
            ptr   <= dst_reg - ADDR_DATA_BASE;
            rem   <= len_reg;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!out_fifo_empty) begin
            entry_reg <= out_fifo_rdata;
            state     <= WR0;
          end else if (timeout_hit) begin
            state <= IDLE;
          end
        end
        WR0: begin
          ptr   <= ptr + 32'd4;
          state <= WR1;
        end
        WR1: begin
          ptr   <= ptr + 32'd4;
          rem   <= rem - 32'd2;
          state <= (rem == 32'd2) ? IDLE : WAIT;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_fifo_pop = (state == WAIT) && !out_fifo_empty;
  assign dma_wr_en    = (state == WR0) || (state == WR1);
  assign dma_wr_addr  = dma_wr_en ? ptr : 32'd0;
  assign dma_wr_be    = {4{dma_wr_en}};

  // Low word first, then high word of the latched entry
  always_comb begin
    dma_wr_data = 32'd0;
    if (state == WR0) dma_wr_data = entry_reg[31:0];
    if (state == WR1) dma_wr_data = entry_reg[63:32];
  end

  // Combinational register readback
  always_comb begin
    rdata = 32'd0;
    case (reg_off)
      OUT_DMA_REG_DST:  rdata = dst_reg;
      OUT_DMA_REG_LEN:  rdata = len_reg;
      OUT_DMA_REG_CTRL: rdata = {28'd0, busy, err_bit, done_bit, 1'b0};
      OUT_DMA_REG_CNT:  rdata = words_done;
      default:          rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_out_dma_engine.sv
// Bench for out_dma_engine: directed scenarios plus randomized runs against a list model.
// FIFO is a first-word-fall-through stub; data_sram writes are captured at the falling edge.
// The timeout scenario is compiled only with OUT_DMA_TIMEOUT_EN.
module tb_out_dma_engine;
  import snn_soc_pkg::*;

  localparam int TO_CYC = 16;
`ifdef OUT_DMA_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic [31:0] rdata;
  logic        out_fifo_pop;
  logic [63:0] out_fifo_rdata;
  logic        out_fifo_empty;
  logic        dma_wr_en;
  logic [31:0] dma_wr_addr, dma_wr_data;
  logic [3:0]  dma_wr_be;

  out_dma_engine #(.ENTRY_W(64), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rdata(rdata),
    .out_fifo_pop(out_fifo_pop), .out_fifo_rdata(out_fifo_rdata),
    .out_fifo_empty(out_fifo_empty),
    .dma_wr_en(dma_wr_en), .dma_wr_addr(dma_wr_addr),
    .dma_wr_data(dma_wr_data), .dma_wr_be(dma_wr_be)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  logic [31:0] last_words = 32'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FWFT FIFO stub: the initial block pushes, the pop commits at the following falling edge
  logic [63:0] fifo_mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic pop_pending = 1'b0;
  assign out_fifo_empty = (wr_ptr == rd_ptr);
  assign out_fifo_rdata = out_fifo_empty ? 64'd0 : fifo_mem[rd_ptr[7:0]];

  task automatic fifo_push(input logic [63:0] v);
    fifo_mem[wr_ptr[7:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  // Observed traffic
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  int          obs_cyc[$];
  int pop_cnt = 0;
  int bad_cnt = 0;

  always @(negedge clk) begin
    if (pop_pending) rd_ptr <= rd_ptr + 1;
    pop_pending <= out_fifo_pop;
    if (out_fifo_pop) begin
      pop_cnt <= pop_cnt + 1;
      if (out_fifo_empty) bad_cnt <= bad_cnt + 1;
    end
    if (dma_wr_en) begin
      if (dma_wr_be !== 4'hF) bad_cnt <= bad_cnt + 1;
      obs_addr.push_back(dma_wr_addr);
      obs_data.push_back(dma_wr_data);
      obs_cyc.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reg_wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] be);
    req_valid = 1'b1; req_write = 1'b1;
    req_addr = {24'd0, off}; req_wdata = d; req_wstrb = be;
    start_cyc = cyc;
    tick(1);
    req_valid = 1'b0; req_write = 1'b0; req_wstrb = 4'h0; req_wdata = 32'd0;
  endtask

  task automatic reg_rd(input logic [7:0] off, output logic [31:0] d);
    req_addr = {24'd0, off};
    #1;
    d = rdata;
  endtask

  task automatic clear_obs();
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
  endtask

  // Reference: what a START with these registers must do (plain 64-bit arithmetic)
  function automatic void exp_start(input logic [31:0] dst, input logic [31:0] len,
                                    output bit run, output bit err);
    longint unsigned d = dst;
    longint unsigned l = len;
    longint unsigned last;
    run = 1'b0; err = 1'b0;
    if (l % 2 != 0) err = 1'b1;
    else if (l != 0) begin
      last = d + 4 * l - 1;
      if ((d % 4 != 0) || (d < ADDR_DATA_BASE) || (last > ADDR_DATA_END)) err = 1'b1;
      else run = 1'b1;
    end
  endfunction

  // Compare captured writes with the expected word list of a run
  task automatic check_writes(input string name, input logic [31:0] dst,
                              input logic [63:0] ent[$], input int nwords);
    logic [63:0] e;
    check({name, ".nwr"}, obs_addr.size(), nwords);
    for (int i = 0; i < obs_addr.size() && i < nwords; i++) begin
      e = ent[i/2];
      check($sformatf("%s.addr%0d", name, i), obs_addr[i], dst - ADDR_DATA_BASE + 4 * i);
      check($sformatf("%s.data%0d", name, i), obs_data[i], (i % 2 != 0) ? e[63:32] : e[31:0]);
    end
  endtask

  logic [63:0] fixed_ent[$];

  task automatic run_case(input string name, input logic [31:0] dst, input logic [31:0] len,
                          input bit gappy);
    logic [63:0] ent[$];
    bit run, err;
    int n, pushed, idle_run, st, pop0, bad0;
    logic [31:0] r;
    exp_start(dst, len, run, err);
    n = run ? int'(len / 2) : 0;
    for (int i = 0; i < n; i++)
      ent.push_back((fixed_ent.size() > i) ? fixed_ent[i] : {$urandom, $urandom});
    clear_obs();
    pop0 = pop_cnt; bad0 = bad_cnt;
    reg_wr(OUT_DMA_REG_DST, dst, 4'hF);
    reg_wr(OUT_DMA_REG_LEN, len, 4'hF);
    pushed = 0;
    if (!run) fifo_push(64'hDEAD_BEEF_0BAD_F00D);
    else begin
      idle_run = gappy ? $urandom_range(0, n) : n;
      while (pushed < idle_run) begin fifo_push(ent[pushed]); pushed++; end
    end
    reg_wr(OUT_DMA_REG_CTRL, 32'h1, 4'hF);
    st = start_cyc;
    idle_run = 0;
    r = 32'd0;
    for (int c = 0; c < 600; c++) begin
      if (pushed < n && ($urandom_range(0, 2) == 0 || idle_run >= 5)) begin
        fifo_push(ent[pushed]); pushed++; idle_run = 0;
      end else idle_run++;
      reg_rd(OUT_DMA_REG_CTRL, r);
      if (!r[3]) break;
      tick(1);
    end
    check({name, ".ctrl"}, r, {28'd0, 1'b0, err, 1'b1, 1'b0});
    if (run) last_words = len;
    reg_rd(OUT_DMA_REG_CNT, r);
    check({name, ".words"}, r, last_words);
    tick(2);
    check_writes(name, dst, ent, run ? int'(len) : 0);
    check({name, ".pops"}, pop_cnt - pop0, n);
    check({name, ".proto"}, bad_cnt - bad0, 0);
    if (!run) wr_ptr = rd_ptr;
    if (run && !gappy && obs_cyc.size() >= int'(len)) begin
      check({name, ".lat"}, obs_cyc[0] - st, 2);
      for (int k = 1; k < n; k++)
        check($sformatf("%s.gap%0d", name, k), obs_cyc[2*k] - obs_cyc[2*k-2], 3);
    end
    reg_wr(OUT_DMA_REG_CTRL, 32'h6, 4'hF);
    reg_rd(OUT_DMA_REG_CTRL, r);
    check({name, ".clr"}, r, 32'd0);
    tick(1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] r, dst, len;
    logic [63:0] ent[$];
    int pop0, st, mode;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; req_wstrb = 4'h0;
    tick(2);
    // Reset state
    check("rst.wr_en", dma_wr_en, 0);
    check("rst.wr_addr", dma_wr_addr, 0);
    check("rst.wr_data", dma_wr_data, 0);
    check("rst.wr_be", dma_wr_be, 0);
    check("rst.pop", out_fifo_pop, 0);
    for (int a = 0; a < 4; a++) begin
      reg_rd(8'(4 * a), r);
      check($sformatf("rst.reg%0d", a), r, 0);
    end
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // Byte-enabled register write
    reg_wr(OUT_DMA_REG_DST, 32'h1234_5678, 4'hF);
    reg_wr(OUT_DMA_REG_DST, 32'hFFFF_FFFF, 4'b0101);
    reg_rd(OUT_DMA_REG_DST, r);
    check("wstrb.dst", r, 32'h12FF_56FF);
    reg_rd(8'h10, r);
    check("unmapped", r, 0);

    // Hardware set beats a same-cycle W1C
    reg_wr(OUT_DMA_REG_LEN, 32'd0, 4'hF);
    reg_wr(OUT_DMA_REG_CTRL, 32'h3, 4'hF);
    reg_rd(OUT_DMA_REG_CTRL, r);
    check("setwins.len0", r, 32'h2);
    reg_wr(OUT_DMA_REG_LEN, 32'd3, 4'hF);
    reg_wr(OUT_DMA_REG_CTRL, 32'h7, 4'hF);
    reg_rd(OUT_DMA_REG_CTRL, r);
    check("setwins.odd", r, 32'h6);
    reg_wr(OUT_DMA_REG_CTRL, 32'h6, 4'hF);
    tick(1);

    // Directed scenarios
    fixed_ent = '{64'h1111_2222_3333_4444, 64'hAAAA_BBBB_CCCC_DDDD};
    run_case("normal", ADDR_DATA_BASE + 32'h100, 32'd4, 1'b0);
    fixed_ent.delete();
    run_case("len3", ADDR_DATA_BASE + 32'h100, 32'd3, 1'b0);
    run_case("len0", ADDR_DATA_BASE, 32'd0, 1'b0);
    run_case("rng_end", ADDR_DATA_END - 32'd3, 32'd2, 1'b0);
    run_case("rng_mis", ADDR_DATA_BASE + 32'd2, 32'd2, 1'b0);
    run_case("rng_low", ADDR_DATA_BASE - 32'd4, 32'd2, 1'b0);
    run_case("rng_wrap", 32'hFFFF_FFF8, 32'h4000_0002, 1'b0);
    run_case("end_fit", ADDR_DATA_END - 32'd7, 32'd2, 1'b0);

    // Starved FIFO, second START mid-run must be ignored
    clear_obs();
    pop0 = pop_cnt;
    ent = '{64'h0102_0304_0506_0708, 64'h90A0_B0C0_D0E0_F000};
    reg_wr(OUT_DMA_REG_DST, ADDR_DATA_BASE + 32'h40, 4'hF);
    reg_wr(OUT_DMA_REG_LEN, 32'd4, 4'hF);
    reg_wr(OUT_DMA_REG_CTRL, 32'h1, 4'hF);
    tick(TIMEOUT_ON ? 10 : 50);
    reg_rd(OUT_DMA_REG_CTRL, r);
    check("starve.busy", r[3], 1);
    check("starve.nwr", obs_addr.size(), 0);
    check("starve.pops", pop_cnt - pop0, 0);
    fifo_push(ent[0]);
    tick(3);
    reg_wr(OUT_DMA_REG_CTRL, 32'h1, 4'hF);
    fifo_push(ent[1]);
    for (int c = 0; c < 100; c++) begin
      reg_rd(OUT_DMA_REG_CTRL, r);
      if (!r[3]) break;
      tick(1);
    end
    tick(5);
    reg_rd(OUT_DMA_REG_CTRL, r);
    check("starve.ctrl", r, 32'h2);
    reg_rd(OUT_DMA_REG_CNT, r);
    check("starve.words", r, 4);
    last_words = 32'd4;
    check("starve.pops2", pop_cnt - pop0, 2);
    check_writes("starve", ADDR_DATA_BASE + 32'h40, ent, 4);
    reg_wr(OUT_DMA_REG_CTRL, 32'h6, 4'hF);

    // Reset in WR1 of the first entry
    clear_obs();
    pop0 = pop_cnt;
    fifo_push(64'h5555_6666_7777_8888);
    fifo_push(64'h9999_AAAA_BBBB_CCCC);
    reg_wr(OUT_DMA_REG_DST, ADDR_DATA_BASE + 32'h200, 4'hF);
    reg_wr(OUT_DMA_REG_LEN, 32'd4, 4'hF);
    reg_wr(OUT_DMA_REG_CTRL, 32'h1, 4'hF);
    tick(2);
    check("rstrun.wr1_en", dma_wr_en, 1);
    check("rstrun.wr1_addr", dma_wr_addr, 32'h204);
    rst_n = 1'b0;
    #1;
    check("rstrun.wr_en", dma_wr_en, 0);
    check("rstrun.wr_addr", dma_wr_addr, 0);
    check("rstrun.wr_data", dma_wr_data, 0);
    check("rstrun.wr_be", dma_wr_be, 0);
    check("rstrun.pop", out_fifo_pop, 0);
    tick(1);
    reg_rd(OUT_DMA_REG_DST, r);  check("rstrun.dst", r, 0);
    reg_rd(OUT_DMA_REG_LEN, r);  check("rstrun.len", r, 0);
    reg_rd(OUT_DMA_REG_CTRL, r); check("rstrun.ctrl", r, 0);
    tick(2);
    rst_n = 1'b1;
    tick(6);
    check("rstrun.nwr", obs_addr.size(), 1);
    check("rstrun.pops", pop_cnt - pop0, 1);
    reg_rd(OUT_DMA_REG_CNT, r);
    check("rstrun.words", r, 0);
    last_words = 32'd0;
    wr_ptr = rd_ptr;
    tick(1);

    // Randomized runs: valid transfers with bursty FIFO arrival and assorted bad STARTs
    for (int t = 0; t < 12; t++) begin
      mode = $urandom_range(0, 3);
      len = 32'(2 * $urandom_range(1, 4));
      dst = ADDR_DATA_BASE + 32'(4 * $urandom_range(0, 4096 - int'(len)));
      if (mode == 2) len = len + 32'd1;
      if (mode == 3) dst = $urandom;
      run_case($sformatf("rnd%0d", t), dst, len, mode == 1);
    end

`ifdef OUT_DMA_TIMEOUT_EN
    // One entry, then starvation: ERR+DONE after TO_CYC cycles in WAIT
    clear_obs();
    pop0 = pop_cnt;
    reg_wr(OUT_DMA_REG_DST, ADDR_DATA_BASE, 4'hF);
    reg_wr(OUT_DMA_REG_LEN, 32'd4, 4'hF);
    fifo_push(64'hCAFE_F00D_1234_5678);
    reg_wr(OUT_DMA_REG_CTRL, 32'h1, 4'hF);
    st = start_cyc;
    while (cyc < st + 3 + TO_CYC) tick(1);
    reg_rd(OUT_DMA_REG_CTRL, r);
    check("tmo.before", r, 32'h8);
    tick(1);
    reg_rd(OUT_DMA_REG_CTRL, r);
    check("tmo.after", r, 32'h6);
    reg_rd(OUT_DMA_REG_CNT, r);
    check("tmo.words", r, 2);
    check("tmo.nwr", obs_addr.size(), 2);
    check("tmo.pops", pop_cnt - pop0, 1);
    reg_wr(OUT_DMA_REG_CTRL, 32'h6, 4'hF);
`endif

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
